// File: rtl/pix_buff_rd.sv
// pix_buff_rd: issues pixel-FIFO reads under a credit limit, absorbs the read latency in a
// prefetch buffer and unpacks 240-bit words into 24-bit pixels. Define PIX_BUFF_RD_MSB_FIRST_EN for MSB-first order.
module pix_buff_rd #(
    parameter int unsigned WORD_W       = 240,
    parameter int unsigned PIX_W        = 24,
    parameter int unsigned PIX_PER_WORD = 10,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned LINE_WORDS   = 64,
    parameter int unsigned PBUF_DEPTH   = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              flush,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_eol,
    output logic [9:0]        pix_x
);
    localparam int unsigned X_W      = 10;
    localparam int unsigned LINE_PIX = LINE_WORDS * PIX_PER_WORD;
    localparam int unsigned PTR_W    = (PBUF_DEPTH > 1) ? $clog2(PBUF_DEPTH) : 1;
    localparam int unsigned OCC_W    = $clog2(PBUF_DEPTH + 1);
    localparam int unsigned OUT_W    = $clog2(RD_LAT + 1);
    localparam int unsigned IDX_W    = $clog2(PIX_PER_WORD);

    typedef enum logic {S_EMPTY, S_ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PIX_W-1:0]   data_d;
    logic [X_W-1:0]     x_d;
    logic               eol_d;

    logic [WORD_W-1:0]  pbuf [PBUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [RD_LAT-1:0]  sr_v, sr_drop;

    logic               ret, avail, load, pop, push, hs;
    logic [WORD_W-1:0]  src_word;

    function automatic logic [PIX_W-1:0] first_pix(input logic [WORD_W-1:0] w);
`ifdef PIX_BUFF_RD_MSB_FIRST_EN
        return w[WORD_W-1 -: PIX_W];
`else
        return w[PIX_W-1:0];
`endif
    endfunction

    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
`ifdef PIX_BUFF_RD_MSB_FIRST_EN
        return w << PIX_W;
`else
        return w >> PIX_W;
`endif
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PBUF_DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    // Credit: never more words issued or buffered than prefetch slots.
    assign fifo_rd_en = rd_rst_n && !fifo_empty && !flush &&
                        ((32'(out_q) + 32'(occ_q)) < PBUF_DEPTH);

    // Unpacker next-state; a returning word bypasses the buffer when it is empty.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        data_d   = pix_data;
        x_d      = pix_x;
        eol_d    = pix_eol;
        load     = 1'b0;
        hs       = pix_valid && pix_ready;
        ret      = sr_v[RD_LAT-1] && !sr_drop[RD_LAT-1] && !flush;
        avail    = (occ_q != '0) || ret;
        src_word = (occ_q != '0) ? pbuf[rd_ptr] : fifo_rd_data;

        case (state_q)
            S_EMPTY: begin
                if (avail) load = 1'b1;
            end
            S_ACTIVE: begin
                if (hs) begin
                    if (idx_q == IDX_W'(PIX_PER_WORD - 1)) begin
                        if (avail) load = 1'b1;
                        else       state_d = S_EMPTY;
                    end else begin
                        data_d = first_pix(word_q);
                        word_d = next_word(word_q);
                        idx_d  = IDX_W'(idx_q + 1'b1);
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (hs) x_d = pix_eol ? '0 : X_W'(pix_x + 1'b1);
        eol_d = (x_d == X_W'(LINE_PIX - 1));

        if (flush) begin
            state_d = S_EMPTY;
            x_d     = '0;
            eol_d   = 1'b0;
            load    = 1'b0;
        end

        if (load) begin
            state_d = S_ACTIVE;
            data_d  = first_pix(src_word);
            word_d  = next_word(src_word);
            idx_d   = '0;
        end

        pop  = load && (occ_q != '0);
        push = ret && !(load && (occ_q == '0));

        case ({push, pop})
            2'b10:   occ_d = OCC_W'(occ_q + 1'b1);
            2'b01:   occ_d = OCC_W'(occ_q - 1'b1);
            default: occ_d = occ_q;
        endcase

        case ({fifo_rd_en, sr_v[RD_LAT-1]})
            2'b10:   out_d = OUT_W'(out_q + 1'b1);
            2'b01:   out_d = OUT_W'(out_q - 1'b1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_q   <= S_EMPTY;
            word_q    <= '0;
            idx_q     <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_eol   <= 1'b0;
            pix_x     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ_q     <= '0;
            out_q     <= '0;
            sr_v      <= '0;
            sr_drop   <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            pix_data  <= data_d;
            pix_valid <= (state_d == S_ACTIVE);
            pix_eol   <= eol_d;
            pix_x     <= x_d;
            out_q     <= out_d;
            // In-flight reads keep counting as outstanding but are tagged for discard on flush.
            sr_v[0]    <= fifo_rd_en;
            sr_drop[0] <= 1'b0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                sr_v[i]    <= sr_v[i-1];
                sr_drop[i] <= sr_drop[i-1] | flush;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ_q  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                occ_q <= occ_d;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst_n && push) pbuf[wr_ptr] <= fifo_rd_data;
    end

endmodule

// File: tb/tb_pix_buff_rd.sv
// tb_pix_buff_rd: directed bench for pix_buff_rd with a latency-2 FIFO model and a pixel scoreboard.
module tb_pix_buff_rd;
    localparam int unsigned WORD_W   = 240;
    localparam int unsigned PIX_W    = 24;
    localparam int          PPW      = 10;
    localparam int          LINE_PIX = 640;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] fifo_rd_data;
    logic              fifo_empty = 1'b1;
    logic              flush = 1'b0;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready = 1'b1;
    logic              pix_eol;
    logic [9:0]        pix_x;

    always #5 clk = ~clk;

    pix_buff_rd dut (
        .rd_clk       (clk),
        .rd_rst_n     (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .flush        (flush),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_eol      (pix_eol),
        .pix_x        (pix_x)
    );

    // FIFO model: output-registered, data valid two cycles after the read strobe.
    logic [WORD_W-1:0] fq[$];
    int                fq_id[$];
    logic [WORD_W-1:0] rd_d1 = '0, rd_d2 = '0;
    int                issued = 0;
    bit                tog_mode = 1'b0, fe_phase = 1'b0;
    assign fifo_rd_data = rd_d2;

    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            rd_d1 <= fq.pop_front();
            fq_id.delete(0);
            issued <= issued + 1;
        end
        rd_d2      <= rd_d1;
        fifo_empty <= (fq.size() == 0) || (tog_mode && !fe_phase);
        fe_phase   <= !fe_phase;
    end

    typedef struct {
        logic [PIX_W-1:0] d;
        int               k;
    } exp_t;

    typedef struct {
        bit rdy;
        bit e_rd;
        bit e_v;
        int e_k;
    } vec_t;

    exp_t exp_q[$];
    int   exp_x = 0;
    bit   front_seen = 1'b0;
    int   started = 0, base_issued = 0, base_started = 0;
    bit   bound_en = 1'b0, bubble_en = 1'b0, stream_seen = 1'b0;
    int   bubbles = 0, eol_cnt = 0, next_id = 1;
    int   total = 0, bad = 0;

    function automatic void chk(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [PIX_W-1:0] pval(input int id, input int k);
        return PIX_W'((id << 8) | k);
    endfunction

    function automatic logic [WORD_W-1:0] pack(input int id);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < PPW; k++) begin
`ifdef PIX_BUFF_RD_MSB_FIRST_EN
            w[WORD_W-1-k*PIX_W -: PIX_W] = pval(id, k);
`else
            w[k*PIX_W +: PIX_W] = pval(id, k);
`endif
        end
        return w;
    endfunction

    task automatic push_word();
        exp_t e;
        fq.push_back(pack(next_id));
        fq_id.push_back(next_id);
        for (int k = 0; k < PPW; k++) begin
            e.d = pval(next_id, k);
            e.k = k;
            exp_q.push_back(e);
        end
        next_id++;
    endtask

    // One cycle: check outputs at the falling edge, then drive flush/ready for the next rising edge.
    task automatic step(input bit fl, input bit rnd);
        exp_t e;
        int   occ;
        @(negedge clk);
        chk(!(fifo_rd_en && fifo_empty), "rd_en_while_empty", 64'(fifo_rd_en), 0);
        if (pix_valid) begin
            chk(exp_q.size() > 0, "extra_pixel", 64'(pix_data), 0);
            if (exp_q.size() > 0) begin
                chk(pix_data == exp_q[0].d, "pix_data", 64'(pix_data), 64'(exp_q[0].d));
                chk(pix_x == 10'(exp_x), "pix_x", 64'(pix_x), 64'(exp_x));
                chk(pix_eol == (exp_x == LINE_PIX - 1), "pix_eol", 64'(pix_eol), 64'(exp_x == LINE_PIX - 1));
                if (exp_q[0].k == 0 && !front_seen) begin
                    started++;
                    front_seen = 1'b1;
                end
            end
            stream_seen = 1'b1;
        end else if (bubble_en && stream_seen && exp_q.size() > 0) begin
            bubbles++;
        end
        if (bound_en) begin
            occ = (issued - base_issued) - (started - base_started);
            chk(occ <= 4, "credit_bound", 64'(occ), 4);
        end
        flush     = fl;
        pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (fl) begin
            exp_q.delete();
            foreach (fq_id[j]) begin
                for (int k = 0; k < PPW; k++) begin
                    e.d = pval(fq_id[j], k);
                    e.k = k;
                    exp_q.push_back(e);
                end
            end
            exp_x      = 0;
            front_seen = 1'b0;
        end else if (pix_valid && pix_ready && exp_q.size() > 0) begin
            if (pix_eol) eol_cnt++;
            exp_q.delete(0);
            front_seen = 1'b0;
            exp_x = (exp_x == LINE_PIX - 1) ? 0 : exp_x + 1;
        end
    endtask

    task automatic drain(input bit rnd, input int maxc, input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            step(1'b0, rnd);
            n++;
        end
        chk(exp_q.size() == 0, name, 64'(exp_q.size()), 0);
        repeat (3) step(1'b0, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              tbl[16];
        logic [WORD_W-1:0] raw;
        int                ek, n;

        // Word with pixel k = k in ascending bit order, read by the table below.
        raw = '0;
        for (int k = 0; k < PPW; k++) raw[k*PIX_W +: PIX_W] = PIX_W'(k);
        fq.push_back(raw);
        fq_id.push_back(-1);

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1};
        for (int i = 7; i <= 14; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, i - 5};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 0};

        // Reset: FIFO already non-empty, strobe must stay low.
        repeat (3) @(negedge clk);
        chk(fifo_rd_en == 1'b0, "rst_rd_en", 64'(fifo_rd_en), 0);
        chk(pix_valid == 1'b0, "rst_valid", 64'(pix_valid), 0);
        chk(pix_data == '0, "rst_data", 64'(pix_data), 0);
        chk(pix_eol == 1'b0, "rst_eol", 64'(pix_eol), 0);
        chk(pix_x == '0, "rst_x", 64'(pix_x), 0);

        // Single word, latency and stall behaviour.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
`ifdef PIX_BUFF_RD_MSB_FIRST_EN
            ek = PPW - 1 - tbl[i].e_k;
`else
            ek = tbl[i].e_k;
`endif
            chk(fifo_rd_en == tbl[i].e_rd, "tbl_rd_en", 64'(fifo_rd_en), 64'(tbl[i].e_rd));
            chk(pix_valid == tbl[i].e_v, "tbl_valid", 64'(pix_valid), 64'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                chk(pix_data == PIX_W'(ek), "tbl_data", 64'(pix_data), 64'(ek));
                chk(pix_x == 10'(tbl[i].e_k), "tbl_x", 64'(pix_x), 64'(tbl[i].e_k));
                chk(pix_eol == 1'b0, "tbl_eol", 64'(pix_eol), 0);
            end
            pix_ready = tbl[i].rdy;
            @(negedge clk);
            #1;
        end
        exp_x = 10;

        // Flush with two reads in flight: both returns dropped, third word starts at x=0.
        push_word();
        push_word();
        push_word();
        step(1'b0, 1'b0);
        chk(fifo_rd_en == 1'b1, "flush_issue0", 64'(fifo_rd_en), 1);
        step(1'b0, 1'b0);
        chk(fifo_rd_en == 1'b1, "flush_issue1", 64'(fifo_rd_en), 1);
        step(1'b1, 1'b0);
        #1;
        chk(fifo_rd_en == 1'b0, "flush_rd_en", 64'(fifo_rd_en), 0);
        drain(1'b0, 100, "flush_drain");

        // Flush mid-word with a handshake pending: valid drops next cycle, x clears.
        push_word();
        n = 0;
        while (exp_q.size() > 7 && n < 60) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk(exp_q.size() == 7, "midflush_reach", 64'(exp_q.size()), 7);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk(pix_valid == 1'b0, "midflush_valid", 64'(pix_valid), 0);
        chk(pix_x == '0, "midflush_x", 64'(pix_x), 0);
        repeat (3) step(1'b0, 1'b0);

        // Full line back-to-back.
        base_issued  = issued;
        base_started = started;
        bound_en     = 1'b1;
        bubble_en    = 1'b1;
        stream_seen  = 1'b0;
        bubbles      = 0;
        eol_cnt      = 0;
        for (int w = 0; w < 64; w++) push_word();
        drain(1'b0, 1000, "line_drain");
        chk(bubbles == 0, "line_bubbles", 64'(bubbles), 0);
        chk(eol_cnt == 1, "line_eol_count", 64'(eol_cnt), 1);
        chk(pix_x == '0, "line_x_wrap", 64'(pix_x), 0);
        bubble_en = 1'b0;

        // Random backpressure over two lines.
        base_issued  = issued;
        base_started = started;
        for (int w = 0; w < 128; w++) push_word();
        drain(1'b1, 6000, "rand_drain");

        // fifo_empty toggling every cycle.
        base_issued  = issued;
        base_started = started;
        tog_mode = 1'b1;
        for (int w = 0; w < 8; w++) push_word();
        drain(1'b0, 600, "toggle_drain");
        tog_mode = 1'b0;
        bound_en = 1'b0;

        repeat (3) step(1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
